// File: rtl/lsu_axi_if.sv
// Request/response and AXI4-Lite signal bundle for the load/store unit.
// master = the LSU itself; slave = core pipeline plus data-cache side.
interface lsu_axi_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_fault;

  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [2:0]  m_arprot;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;

  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [2:0]  m_awprot;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault,
    input  m_arready, m_rdata, m_rresp, m_rvalid,
    output m_araddr, m_arvalid, m_arprot, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid,
    output m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
    output m_arready, m_rdata, m_rresp, m_rvalid,
    input  m_araddr, m_arvalid, m_arprot, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid,
    input  m_awaddr, m_awvalid, m_awprot, m_wdata, m_wstrb, m_wvalid, m_bready
  );
endinterface

// File: rtl/lsu_axi.sv
// Load/store unit: one RISC-V load/store at a time turned into a word-aligned
// AXI4-Lite transaction, with alignment/funct3 checks and registered outputs.
module lsu_axi #(
  parameter logic [2:0] PROT = 3'b000
) (
  input logic       clk,
  input logic       rstn,
  lsu_axi_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_e;

  state_e      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic        awvalid_q, awvalid_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_fault_q, rsp_fault_d;

  logic        f3_bad, misal, aw_done, w_done;
  logic [31:0] sh, ld_val;

  always_comb begin
    if (bus.req_we) f3_bad = (bus.req_funct3 > 3'd2);
    else            f3_bad = bus.req_funct3 inside {3'd3, 3'd6, 3'd7};
    case (bus.req_funct3)
      3'd1, 3'd5: misal = bus.req_addr[0];
      3'd2:       misal = |bus.req_addr[1:0];
      default:    misal = 1'b0;
    endcase
  end

  always_comb begin
    sh = bus.m_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    ld_val = {{24{sh[7]}}, sh[7:0]};
      3'd4:    ld_val = {24'b0, sh[7:0]};
      3'd1:    ld_val = {{16{sh[15]}}, sh[15:0]};
      3'd5:    ld_val = {16'b0, sh[15:0]};
      default: ld_val = sh;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    f3_d        = f3_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    aw_done     = !awvalid_q || bus.m_awready;
    w_done      = !wvalid_q || bus.m_wready;

    case (state_q)
      IDLE: if (bus.req_valid) begin
        off_d = bus.req_addr[1:0];
        f3_d  = bus.req_funct3;
        if (f3_bad || misal) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_fault_d = f3_bad ? 2'd2 : 2'd1;
        end else if (bus.req_we) begin
          state_d   = WR_REQ;
          awaddr_d  = {bus.req_addr[31:2], 2'b00};
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          case (bus.req_funct3)
            3'd0: begin
              wstrb_d = 4'b0001 << bus.req_addr[1:0];
              wdata_d = {4{bus.req_wdata[7:0]}};
            end
            3'd1: begin
              wstrb_d = 4'b0011 << bus.req_addr[1:0];
              wdata_d = {2{bus.req_wdata[15:0]}};
            end
            default: begin
              wstrb_d = 4'b1111;
              wdata_d = bus.req_wdata;
            end
          endcase
        end else begin
          state_d   = RD_ADDR;
          araddr_d  = {bus.req_addr[31:2], 2'b00};
          arvalid_d = 1'b1;
        end
      end
      RD_ADDR: if (bus.m_arready) begin
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        state_d   = RD_DATA;
      end
      RD_DATA: if (bus.m_rvalid) begin
        rready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_fault_d = (bus.m_rresp != 2'b00) ? 2'd3 : 2'd0;
        rsp_rdata_d = (bus.m_rresp != 2'b00) ? '0 : ld_val;
        state_d     = RSP;
      end
      // AW and W complete independently; a channel already done counts as done.
      WR_REQ: begin
        if (bus.m_awready) awvalid_d = 1'b0;
        if (bus.m_wready)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: if (bus.m_bvalid) begin
        bready_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_fault_d = (bus.m_bresp != 2'b00) ? 2'd3 : 2'd0;
        state_d     = RSP;
      end
      RSP: if (bus.rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      off_q       <= '0;
      f3_q        <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= '0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_arprot  = PROT;
  assign bus.m_rready  = rready_q;
  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_awvalid = awvalid_q;
  assign bus.m_awprot  = PROT;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wstrb_q;
  assign bus.m_wvalid  = wvalid_q;
  assign bus.m_bready  = bready_q;
endmodule

// File: tb/tb_lsu_axi.sv
// Bench for lsu_axi: directed and random loads/stores against a byte-level
// reference model, with an AXI slave emulated inline and a handshake monitor.
module tb_lsu_axi;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  lsu_axi_if bus ();
  lsu_axi #(.PROT(3'b000)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int unsigned n_pass = 0, n_total = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned b2i(input logic b);
    return (b === 1'b1) ? 1 : 0;
  endfunction

  // Handshake monitor: a valid seen without its ready must persist unchanged.
  int unsigned proto_err = 0, ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
  logic        mon_ok = 1'b0;
  logic        p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0, p_rs = 1'b0;
  logic [31:0] p_ara, p_awa, p_wd, p_rsd;
  logic [3:0]  p_ws;
  logic [1:0]  p_rsf;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) mon_ok <= 1'b0;
    else begin
      mon_ok <= 1'b1;
      ar_cnt <= ar_cnt + b2i(bus.m_arvalid);
      aw_cnt <= aw_cnt + b2i(bus.m_awvalid);
      w_cnt  <= w_cnt + b2i(bus.m_wvalid);
      if (mon_ok)
        proto_err <= proto_err
          + b2i(p_ar && !(bus.m_arvalid && bus.m_araddr == p_ara))
          + b2i(p_aw && !(bus.m_awvalid && bus.m_awaddr == p_awa))
          + b2i(p_w && !(bus.m_wvalid && bus.m_wdata == p_wd && bus.m_wstrb == p_ws))
          + b2i(p_rs && !(bus.rsp_valid && bus.rsp_rdata == p_rsd && bus.rsp_fault == p_rsf));
      p_ar  <= bus.m_arvalid && !bus.m_arready;
      p_aw  <= bus.m_awvalid && !bus.m_awready;
      p_w   <= bus.m_wvalid && !bus.m_wready;
      p_rs  <= bus.rsp_valid && !bus.rsp_ready;
      p_ara <= bus.m_araddr;
      p_awa <= bus.m_awaddr;
      p_wd  <= bus.m_wdata;
      p_ws  <= bus.m_wstrb;
      p_rsd <= bus.rsp_rdata;
      p_rsf <= bus.rsp_fault;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: access size, legality and byte lanes from the ISA rules.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [2:0] f3, input logic [31:0] rd, input logic [1:0] resp,
                                output logic [1:0] fault, output logic [31:0] rdata,
                                output logic [3:0] strb, output logic [31:0] wdata,
                                output bit traffic);
    int unsigned size, off;
    longint v;
    bit legal;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      default:    size = 4;
    endcase
    off = 32'(addr[1:0]);
    traffic = 1'b0;
    rdata = '0;
    strb = '0;
    wdata = '0;
    fault = 2'd0;
    if (!legal) fault = 2'd2;
    else if ((addr % size) != 0) fault = 2'd1;
    else begin
      traffic = 1'b1;
      if (resp != 2'b00) fault = 2'd3;
      if (we) begin
        for (int unsigned j = 0; j < 4; j++) begin
          strb[j] = (j >= off) && (j < off + size);
          wdata[8*j +: 8] = wd[8*(j % size) +: 8];
        end
      end else if (resp == 2'b00) begin
        v = 0;
        for (int unsigned i = 0; i < size; i++)
          v += longint'(rd[8*(off+i) +: 8]) << (8*i);
        if (f3 < 3'd4 && v >= (longint'(1) << (8*size - 1))) v -= longint'(1) << (8*size);
        rdata = v[31:0];
      end
    end
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] rd, input logic [1:0] resp,
                         input int unsigned d_a, input int unsigned d_w, input int unsigned d_r,
                         input int unsigned hold, input bit chk_lat);
    logic [1:0]  e_fault;
    logic [31:0] e_rdata, e_wdata;
    logic [3:0]  e_strb;
    bit          traffic, aw_done, w_done;
    int unsigned c1, n, aw_wait, w_wait, b_cyc, ar0, aw0, w0;
    model(we, addr, wd, f3, rd, resp, e_fault, e_rdata, e_strb, e_wdata, traffic);
    ar0 = ar_cnt; aw0 = aw_cnt; w0 = w_cnt;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wd;   bus.req_funct3 = f3;
    check("req_ready_idle", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    c1 = cyc;
    if (traffic && !we) begin
      n = 0;
      while (bus.m_arvalid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      check("arvalid", 32'(bus.m_arvalid), 1);
      if (chk_lat) check("ar_cycle", cyc - c1, 0);
      check("araddr", bus.m_araddr, addr & ~32'd3);
      check("arprot", 32'(bus.m_arprot), 0);
      repeat (d_a) @(negedge clk);
      bus.m_arready = 1'b1;
      @(negedge clk);
      bus.m_arready = 1'b0;
      n = 0;
      while (bus.m_rready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      check("rready", 32'(bus.m_rready), 1);
      if (chk_lat) check("r_cycle", cyc - c1, 1);
      repeat (d_r) @(negedge clk);
      bus.m_rvalid = 1'b1; bus.m_rdata = rd; bus.m_rresp = resp;
      @(negedge clk);
      bus.m_rvalid = 1'b0; bus.m_rdata = $urandom; bus.m_rresp = 2'($urandom_range(0, 3));
      check("rready_drop", 32'(bus.m_rready), 0);
    end else if (traffic && we) begin
      n = 0;
      while (bus.m_awvalid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      check("awvalid", 32'(bus.m_awvalid), 1);
      check("wvalid_with_aw", 32'(bus.m_wvalid), 1);
      if (chk_lat) check("aw_cycle", cyc - c1, 0);
      check("awaddr", bus.m_awaddr, addr & ~32'd3);
      check("awprot", 32'(bus.m_awprot), 0);
      check("wstrb", 32'(bus.m_wstrb), 32'(e_strb));
      check("wdata", bus.m_wdata, e_wdata);
      aw_done = 1'b0; w_done = 1'b0; aw_wait = 0; w_wait = 0; n = 0;
      while (!(aw_done && w_done) && n < 64) begin
        if (!aw_done) begin if (aw_wait == d_a) bus.m_awready = 1'b1; else aw_wait++; end
        if (!w_done)  begin if (w_wait == d_w)  bus.m_wready  = 1'b1; else w_wait++;  end
        @(negedge clk);
        n++;
        if (bus.m_awready) begin bus.m_awready = 1'b0; aw_done = 1'b1; end
        if (bus.m_wready)  begin bus.m_wready  = 1'b0; w_done  = 1'b1; end
        if (w_done && !aw_done) begin
          check("w_dropped", 32'(bus.m_wvalid), 0);
          check("aw_held", 32'(bus.m_awvalid), 1);
        end
        if (aw_done && !w_done) begin
          check("aw_dropped", 32'(bus.m_awvalid), 0);
          check("w_held", 32'(bus.m_wvalid), 1);
        end
      end
      check("aw_w_done", 32'(aw_done && w_done), 1);
      n = 0;
      while (bus.m_bready !== 1'b1 && n < 64) begin @(negedge clk); n++; end
      check("bready", 32'(bus.m_bready), 1);
      if (chk_lat) check("b_cycle", cyc - c1, 1);
      b_cyc = 1;
      repeat (d_r) begin @(negedge clk); b_cyc += b2i(bus.m_bready); end
      bus.m_bvalid = 1'b1; bus.m_bresp = resp;
      @(negedge clk);
      bus.m_bvalid = 1'b0; bus.m_bresp = 2'($urandom_range(0, 3));
      check("bready_cycles", b_cyc, d_r + 1);
      check("bready_drop", 32'(bus.m_bready), 0);
    end
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    check("rsp_valid", 32'(bus.rsp_valid), 1);
    if (chk_lat) check("rsp_cycle", cyc - c1, traffic ? 2 : 0);
    check("rsp_fault", 32'(bus.rsp_fault), 32'(e_fault));
    check("rsp_rdata", bus.rsp_rdata, e_rdata);
    check("req_ready_busy", 32'(bus.req_ready), 0);
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_fault", 32'(bus.rsp_fault), 32'(e_fault));
      check("hold_rdata", bus.rsp_rdata, e_rdata);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", 32'(bus.rsp_valid), 0);
    check("req_ready_back", 32'(bus.req_ready), 1);
    check("ar_cycles", ar_cnt - ar0, (traffic && !we) ? d_a + 1 : 0);
    check("aw_cycles", aw_cnt - aw0, (traffic && we) ? d_a + 1 : 0);
    check("w_cycles", w_cnt - w0, (traffic && we) ? d_w + 1 : 0);
  endtask

  initial begin
    int unsigned n;
    rstn = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_funct3 = '0; bus.rsp_ready = 1'b0;
    bus.m_arready = 1'b0; bus.m_rdata = '0; bus.m_rresp = '0; bus.m_rvalid = 1'b0;
    bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_bresp = '0; bus.m_bvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_valids", {27'b0, bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.rsp_valid, 1'b0}, 0);
    check("rst_readies", {30'b0, bus.m_rready, bus.m_bready}, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_fault", 32'(bus.rsp_fault), 0);
    check("rst_wstrb", 32'(bus.m_wstrb), 0);
    check("rst_araddr", bus.m_araddr, 0);
    check("rst_awaddr", bus.m_awaddr, 0);
    check("rst_wdata", bus.m_wdata, 0);
    check("rst_prot", {26'b0, bus.m_arprot, bus.m_awprot}, 0);
    rstn = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 32'h0000_1003, 32'h0, 3'd0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 1'b1);
    run_txn(1'b0, 32'h0000_1003, 32'h0, 3'd4, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 1'b1);
    run_txn(1'b1, 32'h0000_2002, 32'h0000_BEEF, 3'd1, 32'h0, 2'b00, 0, 0, 0, 0, 1'b1);
    run_txn(1'b1, 32'h0000_2010, 32'h1234_5678, 3'd2, 32'h0, 2'b00, 3, 0, 0, 0, 1'b0);
    run_txn(1'b1, 32'h0000_2011, 32'h0000_00A5, 3'd0, 32'h0, 2'b00, 0, 2, 1, 0, 1'b0);
    run_txn(1'b0, 32'h0000_3001, 32'h0, 3'd2, 32'h0, 2'b00, 0, 0, 0, 0, 1'b1);
    run_txn(1'b1, 32'h0000_3000, 32'h0, 3'd4, 32'h0, 2'b00, 0, 0, 0, 0, 1'b1);
    run_txn(1'b0, 32'h0000_3003, 32'h0, 3'd7, 32'h0, 2'b00, 0, 0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_4002, 32'h0, 3'd1, 32'h8001_FFFF, 2'b10, 0, 0, 0, 5, 1'b0);
    run_txn(1'b0, 32'h0000_4002, 32'h0, 3'd1, 32'h8001_FFFF, 2'b00, 1, 0, 2, 2, 1'b0);
    run_txn(1'b0, 32'h0000_4002, 32'h0, 3'd5, 32'h8001_FFFF, 2'b00, 0, 0, 0, 0, 1'b0);
    run_txn(1'b1, 32'h0000_4004, 32'h0, 3'd2, 32'h0, 2'b01, 0, 0, 0, 1, 1'b0);

    // Asynchronous reset while the AR channel is stalled.
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h0000_5000; bus.req_funct3 = 3'd2;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.m_arvalid !== 1'b1 && n < 64) begin @(negedge clk); n++; end
    check("rstmid_arvalid", 32'(bus.m_arvalid), 1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rstmid_valids", {28'b0, bus.m_arvalid, bus.m_awvalid, bus.m_wvalid, bus.rsp_valid}, 0);
    check("rstmid_readies", {30'b0, bus.m_rready, bus.m_bready}, 0);
    check("rstmid_req_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_txn(1'b0, 32'h0000_5004, 32'h0, 3'd2, 32'hCAFE_F00D, 2'b00, 0, 0, 0, 0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      run_txn(1'($urandom_range(0, 1)),
              {16'h0, 16'($urandom)},
              $urandom,
              3'($urandom_range(0, 7)),
              $urandom,
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2), 1'b0);
    end

    check("protocol", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lsu_axi.md
Name: lsu_axi

Overview:
- Load/store unit between the core's memory pipeline stage and the AXI4-Lite slave port of the data cache.
- Takes one load or store request at a time, in RISC-V funct3 encoding.
- Checks alignment and funct3, builds word-aligned AXI-Lite read or write transactions with byte strobes, then returns the load data extended and aligned, or a fault code.
- Single outstanding transaction; all AXI and response outputs are registered.

Parameters:
PROT, 3'b000, value driven on m_arprot and m_awprot (data, secure, unprivileged)

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
req_valid  in  1  request valid
req_ready  out  1  unit idle, request accepted when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
req_funct3  in  3  0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accepted
rsp_rdata  out  32  load result; 0 for stores and for faults
rsp_fault  out  2  0 = OK, 1 = misaligned, 2 = illegal funct3, 3 = bus error
m_araddr  out  32  AXI-Lite AR channel (m_arready in, m_arvalid out, m_arprot out 3)
m_rdata  in  32  AXI-Lite R channel (m_rready out, m_rresp in 2, m_rvalid in)
m_awaddr  out  32  AXI-Lite AW channel (m_awready in, m_awvalid out, m_awprot out 3)
m_wdata  out  32  AXI-Lite W channel (m_wready in, m_wstrb out 4, m_wvalid out)
m_bresp  in  2  AXI-Lite B channel (m_bvalid in, m_bready out)

Behaviour:
- Reset (async, rstn low): state IDLE.
  - req_ready = 1.
  - All m_*valid, m_rready, m_bready, rsp_valid = 0.
  - rsp_rdata = 0, rsp_fault = 0, m_wstrb = 0, addresses and data = 0.
  - m_*prot = PROT always.
- Reset mid-transaction abandons the transaction; the downstream cache is reset by the same rstn.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- req_ready = 1 only in IDLE. On accept, latch we, addr, wdata, funct3.
- Legality check at accept:
  - Loads allow funct3 {0,1,2,4,5}; stores allow {0,1,2}. Anything else -> RSP with fault 2.
  - Misaligned: H/HU with addr[0] != 0, or W with addr[1:0] != 0 -> RSP with fault 1.
  - funct3 check takes priority over the misaligned check.
  - Faulting requests issue no AXI traffic.
- Legal load: go to RD_ADDR.
  - m_araddr = {addr[31:2], 2'b00}, m_arvalid = 1 until the m_arready handshake.
  - Then RD_DATA with m_rready = 1 until m_rvalid.
- Load data extraction:
  - sh = m_rdata >> (8*addr[1:0]).
  - B: sign-extend sh[7:0]; BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0]; HU: zero-extend sh[15:0].
  - W: sh.
- Legal store: go to WR_REQ with m_awvalid = m_wvalid = 1 in the same cycle.
  - m_awaddr = word-aligned addr.
  - m_wstrb: B = 4'b0001 << addr[1:0], H = 4'b0011 << addr[1:0], W = 4'b1111.
  - m_wdata: B = {4{wdata[7:0]}}, H = {2{wdata[15:0]}}, W = wdata.
  - Each valid drops after its own handshake.
  - Leave WR_REQ when both have handshaken, whether in the same cycle or in either order. Then WR_RESP with m_bready = 1 until m_bvalid.
- Bus errors: m_rresp != 0 or m_bresp != 0 -> fault 3, rsp_rdata = 0.
- RSP state:
  - rsp_valid = 1 and rsp_rdata/rsp_fault stable until rsp_ready.
  - Then IDLE, and req_ready rises the following cycle; no request is accepted in the same cycle as the rsp handshake.
- Minimum latency, load (accept at edge 0, zero-wait slave): arvalid in cycle 1, rready in cycle 2, rsp_valid in cycle 3.
- Minimum latency, store (accept at edge 0, zero-wait slave): aw/w in cycle 1, bready in cycle 2, rsp_valid in cycle 3.
- Handshake rules: valids never drop before their handshake; addresses, data and strobes are stable while a valid is high.

Test Plan:
- Load LB addr 0x1003, slave returns 0x80FF_1234 -> araddr 0x1000, rsp_rdata 0xFFFF_FF80, fault 0. Same with LBU -> 0x0000_0080.
- Store SH addr 0x2002, wdata 0x0000_BEEF -> awaddr 0x2000, wstrb 4'b1100, wdata 0xBEEF_BEEF, fault 0, rsp_rdata 0.
- Store SW, slave gives wready 3 cycles before awready -> m_wvalid drops after its handshake, m_awvalid held; exactly one B wait, response OK.
- LW addr 0x3001 -> fault 1, no arvalid ever asserted. Store funct3 = 4 -> fault 2.
- LH addr 0x4002, m_rresp = 2'b10 -> fault 3, rsp_rdata 0. rsp_ready held low 5 cycles -> rsp_valid and fields stable throughout.
- rstn pulsed low while m_arvalid is high and arready stalled -> all valids 0 asynchronously, req_ready = 1; a fresh LW then completes normally.
